// File: rtl/dm_hs.sv
// Handshaked data memory: byte/half/word access, wait states, clear sweep.
// Optional store trace under DM_HS_TRACE_EN.
module dm_hs #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [3:0]    cnt;
    logic          we_q;
    logic [2:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   ram [DEPTH_WORDS];

    logic          accept;
    logic          fire;
    logic          cur_we;
    logic [2:0]    cur_op;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [4:0]    lane;
    logic          is_half;
    logic          is_byte;
    logic [1:0]    err;
    logic [31:0]   word;
    logic [15:0]   sh;
    logic [31:0]   mask;
    logic [31:0]   merged;
    logic [31:0]   ld;

    assign req_ready = (state == IDLE);
    assign accept    = req_ready && req_valid;
    // With zero wait states the access shares the accepting edge.
    assign fire = (accept && LAT == 4'd0) || (state == WAIT && cnt == 4'd0);

    always_comb begin
        cur_we    = accept ? req_we    : we_q;
        cur_op    = accept ? req_op    : op_q;
        cur_addr  = accept ? req_addr  : addr_q;
        cur_wdata = accept ? req_wdata : wdata_q;
        off       = cur_addr - BASE_ADDR;
        idx       = off[AW+1:2];
        lane      = {off[1:0], 3'b000};
        is_half   = (cur_op == 3'd1) || (cur_op == 3'd3);
        is_byte   = (cur_op == 3'd2) || (cur_op == 3'd4);
        err       = 2'd0;
        if ((!is_half && !is_byte && off[1:0] != 2'b00) || (is_half && off[0]))
            err = 2'd1;
        else if ((off >> (AW + 2)) != 32'd0)
            err = 2'd2;
        word = ram[idx];
        sh   = 16'(word >> lane);
        mask = 32'hFFFF_FFFF;
        unique case (1'b1)
            is_half: mask = 32'h0000_FFFF << lane;
            is_byte: mask = 32'h0000_00FF << lane;
            default: mask = 32'hFFFF_FFFF;
        endcase
        merged = (word & ~mask) | ((cur_wdata << lane) & mask);
        case (cur_op)
            3'd1:    ld = {{16{sh[15]}}, sh};
            3'd2:    ld = {{24{sh[7]}}, sh[7:0]};
            3'd3:    ld = {16'h0000, sh};
            3'd4:    ld = {24'h000000, sh[7:0]};
            default: ld = word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR)
            ram[ptr] <= '0;
        else if (fire && cur_we && err == 2'd0)
            ram[idx] <= merged;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            ptr       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
            we_q      <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (fire) begin
                rsp_rdata <= (cur_we || err != 2'd0) ? 32'd0 : ld;
                rsp_err   <= err;
            end
            unique case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= LAT - 4'd1;
                        state   <= (LAT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else cnt <= cnt - 4'd1;
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

`ifdef DM_HS_TRACE_EN
    logic [31:0] pc_q;
    logic [31:0] cur_pc;

    assign cur_pc = accept ? req_pc : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= '0;
        else if (accept) pc_q <= req_pc;
    end

    always @(posedge clk) begin
        if (rst_n && fire && cur_we) begin
            if (err == 2'd0)
                $display("@%h: *%h <= %h", cur_pc,
                         cur_addr & 32'hFFFF_FFFC, merged);
            else
                $display("@%h: DM ERR %0d @%h", cur_pc, err, cur_addr);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^req_pc;
`endif
endmodule
